regfile_mp: RTL and testbench

- Parametrised multi-port integer register file.
- Successor to the single-write, dual-read regfile used by the single-cycle core; targets the pipelined core.
- Adds configurable width/depth/port count, optional write-to-read bypass, a per-register busy scoreboard, and a sequential clear engine instead of a one-shot array reset.
- Sits between decode (read/reserve ports) and writeback (write ports).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 40 ++++
 rtl/regfile_mp.sv | 119 +++++++++++
 tb/tb_regfile_mp.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_IDLE,
    RF_CLEAR
  } rf_state_e;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on reserve, cleared by writeback; a reserve
// to the same register in the same cycle as a write keeps the bit set.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int NUM_WR = 1,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic [NUM_WR-1:0]          wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]  wr_addr_i,
  input  logic                       rsv_en_i,
  input  logic [AW-1:0]              rsv_addr_i,
  output logic [NREG-1:0]            busy_o
);

  logic [NREG-1:0] busy_q;

  // The reserve is assigned last so it overrides a same-cycle writeback clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else if (en_i) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w]) begin
          busy_q[wr_addr_i[w]] <= 1'b0;
        end
      end
      if (rsv_en_i && (rsv_addr_i != AW'(REG_ZERO))) begin
        busy_q[rsv_addr_i] <= 1'b1;
      end
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write bypass,
// busy scoreboard and a one-entry-per-cycle clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  output logic                         ready_o,
  input  logic [NUM_RD-1:0][AW-1:0]    rd_addr_i,
  output logic [NUM_RD-1:0][XLEN-1:0]  rd_data_o,
  output logic [NUM_RD-1:0]            rd_busy_o,
  input  logic [NUM_WR-1:0]            wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]    wr_addr_i,
  input  logic [NUM_WR-1:0][XLEN-1:0]  wr_data_i,
  input  logic                         rsv_en_i,
  input  logic [AW-1:0]                rsv_addr_i
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  rf_state_e        state_q;
  logic [AW-1:0]    ptr_q;
  logic             ready_q;
  logic [XLEN-1:0]  mem [NREG];
  logic [NREG-1:0]  busy;
  logic             idle;

  assign idle    = (state_q == RF_IDLE);
  assign ready_o = ready_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RF_CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        RF_IDLE: begin
          if (clr_i) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        RF_CLEAR: begin
          ptr_q <= ptr_q + AW'(1);
          if (ptr_q == LAST_IDX) begin
            state_q <= RF_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= RF_CLEAR;
          ptr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Later write ports are assigned last, so the highest index wins a collision.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == RF_CLEAR) begin
        mem[ptr_q] <= '0;
      end else begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en_i[w] && (wr_addr_i[w] != ZERO_IDX)) begin
            mem[wr_addr_i[w]] <= wr_data_i[w];
          end
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREG   (NREG),
    .NUM_WR (NUM_WR),
    .AW     (AW)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (idle),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .rsv_en_i   (rsv_en_i),
    .rsv_addr_i (rsv_addr_i),
    .busy_o     (busy)
  );

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data_o[p] = '0;
      rd_busy_o[p] = 1'b0;
      if (idle && (rd_addr_i[p] != ZERO_IDX)) begin
        rd_data_o[p] = mem[rd_addr_i[p]];
        rd_busy_o[p] = busy[rd_addr_i[p]];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w] == rd_addr_i[p])) begin
              rd_data_o[p] = wr_data_i[w];
              rd_busy_o[p] = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp against a behavioural model;
// a second BYPASS=0 instance covers the non-bypassed read timing.
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        clr = 1'b0;
  logic [NUM_RD-1:0][AW-1:0]   rd_addr = '0;
  logic [NUM_WR-1:0]           wr_en = '0;
  logic [NUM_WR-1:0][AW-1:0]   wr_addr = '0;
  logic [NUM_WR-1:0][XLEN-1:0] wr_data = '0;
  logic                        rsv_en = 1'b0;
  logic [AW-1:0]               rsv_addr = '0;

  logic                        ready;
  logic [NUM_RD-1:0][XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]           rd_busy;
  logic                        b0_ready;
  logic [NUM_RD-1:0][XLEN-1:0] b0_rd_data;
  logic [NUM_RD-1:0]           b0_rd_busy;

  int n_vec = 0;
  int n_err = 0;

  logic [XLEN-1:0] m_mem [NREG];
  bit              m_busy [NREG];
  int              sweep_left = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN(XLEN), .NREG(NREG), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .BYPASS(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .ready_o(ready),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr)
  );

  regfile_mp #(
    .XLEN(XLEN), .NREG(NREG), .NUM_RD(NUM_RD), .NUM_WR(1), .BYPASS(0)
  ) dut_b0 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .ready_o(b0_ready),
    .rd_addr_i(rd_addr), .rd_data_o(b0_rd_data), .rd_busy_o(b0_rd_busy),
    .wr_en_i(wr_en[0:0]), .wr_addr_i(wr_addr[0:0]), .wr_data_i(wr_data[0:0]),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr)
  );

  // Reference model: what a read returns given the stored state and the inputs now applied.
  function automatic logic [XLEN-1:0] exp_data(int p);
    logic [XLEN-1:0] v;
    int a;
    a = int'(rd_addr[p]);
    if (sweep_left > 0 || a == 0) return '0;
    v = m_mem[a];
    for (int w = 0; w < NUM_WR; w++)
      if (wr_en[w] && int'(wr_addr[w]) == a) v = wr_data[w];
    return v;
  endfunction

  function automatic logic exp_busy(int p);
    logic b;
    int a;
    a = int'(rd_addr[p]);
    if (sweep_left > 0 || a == 0) return 1'b0;
    b = m_busy[a];
    for (int w = 0; w < NUM_WR; w++)
      if (wr_en[w] && int'(wr_addr[w]) == a) b = 1'b0;
    return b;
  endfunction

  task automatic model_update();
    if (rst) begin
      sweep_left = NREG;
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else if (sweep_left > 0) begin
      m_mem[NREG - sweep_left] = '0;
      sweep_left--;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (wr_en[w] && wr_addr[w] != '0) m_mem[int'(wr_addr[w])] = wr_data[w];
      for (int w = 0; w < NUM_WR; w++)
        if (wr_en[w]) m_busy[int'(wr_addr[w])] = 1'b0;
      if (rsv_en && rsv_addr != '0) m_busy[int'(rsv_addr)] = 1'b1;
      if (clr) sweep_left = NREG;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; rst = 1'b0; wr_en = '0; rsv_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      rd_addr[0] = AW'($urandom_range(0, NREG - 1));
      rd_addr[1] = AW'($urandom_range(0, NREG - 1));
      #1;
      n_vec++;
      if (ready !== 1'b0) begin
        n_err++; $display("[TB] FAIL reset_ready_low cycle %0d: got %b expected 0", i, ready);
      end
      n_vec++;
      if (rd_data[0] !== '0 || rd_busy[0] !== 1'b0) begin
        n_err++; $display("[TB] FAIL reset_read_zero cycle %0d: got %h/%b expected 0/0", i, rd_data[0], rd_busy[0]);
      end
      tick();
    end
    #1;
    n_vec++;
    if (ready !== 1'b1 || b0_ready !== 1'b1) begin
      n_err++; $display("[TB] FAIL reset_ready_high: got %b/%b expected 1/1", ready, b0_ready);
    end
    for (int a = 0; a < NREG; a++) begin
      rd_addr[0] = AW'(a);
      rd_addr[1] = AW'(NREG - 1 - a);
      #1;
      for (int p = 0; p < NUM_RD; p++) begin
        n_vec++;
        if (rd_data[p] !== 32'h0 || rd_busy[p] !== 1'b0) begin
          n_err++; $display("[TB] FAIL reset_contents port %0d addr %0d: got %h/%b expected 00000000/0", p, rd_addr[p], rd_data[p], rd_busy[p]);
        end
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd0;
    #1;
    n_vec++;
    if (rd_data[0] !== 32'hDEADBEEF) begin
      n_err++; $display("[TB] FAIL bypass_same_cycle: got %h expected deadbeef", rd_data[0]);
    end
    n_vec++;
    if (b0_rd_data[0] !== 32'h0) begin
      n_err++; $display("[TB] FAIL nobypass_same_cycle: got %h expected 00000000", b0_rd_data[0]);
    end
    tick();
    wr_en = '0;
    #1;
    n_vec++;
    if (rd_data[0] !== 32'hDEADBEEF || b0_rd_data[0] !== 32'hDEADBEEF) begin
      n_err++; $display("[TB] FAIL bypass_next_cycle: got %h/%h expected deadbeef/deadbeef", rd_data[0], b0_rd_data[0]);
    end
  endtask

  task automatic test_x0();
    wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'h12345678;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
    #1;
    n_vec++;
    if (rd_data[0] !== 32'h0 || rd_busy[0] !== 1'b0 || rd_data[1] !== 32'h0 || rd_busy[1] !== 1'b0) begin
      n_err++; $display("[TB] FAIL x0_same_cycle: got %h/%b expected 00000000/0", rd_data[0], rd_busy[0]);
    end
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (rd_data[0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
      n_err++; $display("[TB] FAIL x0_after: got %h/%b expected 00000000/0", rd_data[0], rd_busy[0]);
    end
  endtask

  task automatic test_dual_write();
    wr_en = 2'b11;
    wr_addr[0] = 5'd7; wr_data[0] = 32'h1;
    wr_addr[1] = 5'd7; wr_data[1] = 32'h2;
    rd_addr[0] = 5'd7; rd_addr[1] = 5'd7;
    #1;
    n_vec++;
    if (rd_data[0] !== 32'h2 || rd_data[1] !== 32'h2) begin
      n_err++; $display("[TB] FAIL dual_write_bypass: got %h/%h expected 2/2", rd_data[0], rd_data[1]);
    end
    tick();
    wr_en = '0;
    #1;
    n_vec++;
    if (rd_data[0] !== 32'h2) begin
      n_err++; $display("[TB] FAIL dual_write_array: got %h expected 00000002", rd_data[0]);
    end
  endtask

  task automatic test_scoreboard();
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd0;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    rsv_en = 1'b0;
    #1;
    n_vec++;
    if (rd_busy[0] !== 1'b1) begin
      n_err++; $display("[TB] FAIL sb_reserved: got %b expected 1", rd_busy[0]);
    end
    wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'hA5;
    #1;
    n_vec++;
    if (rd_busy[0] !== 1'b0 || rd_data[0] !== 32'hA5) begin
      n_err++; $display("[TB] FAIL sb_bypass_mask: got %h/%b expected 000000a5/0", rd_data[0], rd_busy[0]);
    end
    tick();
    wr_en = '0;
    #1;
    n_vec++;
    if (rd_busy[0] !== 1'b0) begin
      n_err++; $display("[TB] FAIL sb_write_clears: got %b expected 0", rd_busy[0]);
    end
    wr_en = 2'b01; rsv_en = 1'b1;
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (rd_busy[0] !== 1'b1 || rd_data[0] !== 32'hA5) begin
      n_err++; $display("[TB] FAIL sb_reserve_wins: got %h/%b expected 000000a5/1", rd_data[0], rd_busy[0]);
    end
  endtask

  task automatic test_clear();
    int cnt;
    wr_en = 2'b01; wr_addr[0] = 5'd1; wr_data[0] = 32'h11;
    rd_addr[0] = 5'd1;
    tick();
    wr_en = '0;
    #1;
    n_vec++;
    if (rd_data[0] !== 32'h11) begin
      n_err++; $display("[TB] FAIL clear_preload: got %h expected 00000011", rd_data[0]);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    // A write in the first sweep cycle and a stray clr pulse must both be ignored.
    for (int i = 0; i < NREG; i++) begin
      wr_en = (i == 0) ? 2'b01 : 2'b00;
      wr_data[0] = 32'h22;
      clr = (i == 5);
      #1;
      n_vec++;
      if (ready !== 1'b0 || rd_data[0] !== 32'h0) begin
        n_err++; $display("[TB] FAIL clear_sweep cycle %0d: got ready %b data %h expected 0/00000000", i, ready, rd_data[0]);
      end
      tick();
    end
    idle_inputs();
    #1;
    n_vec++;
    if (ready !== 1'b1 || rd_data[0] !== 32'h0) begin
      n_err++; $display("[TB] FAIL clear_done: got ready %b data %h expected 1/00000000", ready, rd_data[0]);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    n_vec++;
    if (cnt != NREG) begin
      n_err++; $display("[TB] FAIL clear_restart_len: got %0d cycles expected %0d", cnt, NREG);
    end
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd1;
    #1;
    n_vec++;
    if (rd_busy[0] !== 1'b0 || rd_data[0] !== 32'h0 || rd_data[1] !== 32'h0) begin
      n_err++; $display("[TB] FAIL clear_restart_state: got %h/%b/%h expected 0/0/0", rd_data[0], rd_busy[0], rd_data[1]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < NUM_RD; p++)
        rd_addr[p] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NREG - 1) : $urandom_range(0, 7));
      for (int w = 0; w < NUM_WR; w++) begin
        wr_en[w] = $urandom_range(0, 1) == 1;
        wr_addr[w] = AW'($urandom_range(0, 7));
        wr_data[w] = $urandom;
      end
      rsv_en = $urandom_range(0, 1) == 1;
      rsv_addr = AW'($urandom_range(0, 7));
      #1;
      n_vec++;
      if (ready !== (sweep_left == 0)) begin
        n_err++; $display("[TB] FAIL rand_ready cycle %0d: got %b expected %b", c, ready, sweep_left == 0);
      end
      for (int p = 0; p < NUM_RD; p++) begin
        n_vec++;
        if (rd_data[p] !== exp_data(p) || rd_busy[p] !== exp_busy(p)) begin
          n_err++; $display("[TB] FAIL rand_read cycle %0d port %0d addr %0d: got %h/%b expected %h/%b",
                            c, p, rd_addr[p], rd_data[p], rd_busy[p], exp_data(p), exp_busy(p));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 1'b0;
    end
    test_reset();
    test_bypass();
    test_x0();
    test_dual_write();
    test_scoreboard();
    test_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
